// File: rtl/mips_pkg.sv
// Shared MIPS register-file types and widths used by the writeback path.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_rec_t;

  localparam int unsigned WB_REC_W = $bits(wb_rec_t);

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular FIFO holding mult/div writeback records until the write port is free.
module wb_result_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 37
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Depth is a power of two, so pointers wrap naturally at PtrW bits.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port owner: arbitrates pipeline writeback against queued mult/div results,
// tracks outstanding long-latency destinations and forces a drain slot when the queue starves.
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wbValid,
  input  logic [REG_ADDR_W-1:0]   wbAddr,
  input  logic [DATA_W-1:0]       wbData,
  input  logic                    mdValid,
  output logic                    mdReady,
  input  logic [REG_ADDR_W-1:0]   mdAddr,
  input  logic [DATA_W-1:0]       mdData,
  input  logic                    issueValid,
  input  logic [REG_ADDR_W-1:0]   issueAddr,
  input  logic [REG_ADDR_W-1:0]   query1,
  input  logic [REG_ADDR_W-1:0]   query2,
  output logic                    pending1,
  output logic                    pending2,
  output logic                    stallReq,
  output logic [REG_ADDR_W-1:0]   writeAddr,
  output logic [DATA_W-1:0]       writeData,
  output logic                    writeEn,
  output logic [$clog2(DEPTH):0]  fifoCount
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  wb_rec_t md_rec, head;
  logic    full, empty, sel_fifo;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_REGS-1:0]   sb_q, sb_d;
  logic [StarveW-1:0]    starve_q, starve_d;
  logic                  stall_q, stall_d;

  assign md_rec   = '{addr: mdAddr, data: mdData};
  assign mdReady  = !full;
  assign sel_fifo = !wbValid && !empty;

  wb_result_fifo #(
    .Depth (DEPTH),
    .Width (WB_REC_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (mdValid),
    .pop_i   (sel_fifo),
    .wdata_i (md_rec),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifoCount)
  );

  // Unselected cycles keep the last address/data so the port only toggles on real writes.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wbValid) begin
      we_d    = (wbAddr != REG_ZERO);
      waddr_d = wbAddr;
      wdata_d = wbData;
    end else if (sel_fifo) begin
      we_d    = (head.addr != REG_ZERO);
      waddr_d = head.addr;
      wdata_d = head.data;
    end
  end

  // Issue is applied after the pop clear so a same-cycle set survives.
  always_comb begin
    sb_d = sb_q;
    if (sel_fifo)   sb_d[head.addr] = 1'b0;
    if (issueValid) sb_d[issueAddr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (empty || sel_fifo) begin
      starve_d = '0;
    end else if (wbValid) begin
      starve_d = starve_q + StarveW'(1);
    end
    if (starve_d == StarveW'(STARVE_MAX)) begin
      stall_d  = 1'b1;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      sb_q     <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      sb_q     <= sb_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign writeEn   = we_q;
  assign writeAddr = waddr_q;
  assign writeData = wdata_q;
  assign stallReq  = stall_q;
  assign pending1  = sb_q[query1];
  assign pending2  = sb_q[query2];

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Writer side of the 32x32 MIPS register file. Owns the single write port (writeAddr/writeData/writeEn).
- Arbitrates between two result sources:
  - the in-order pipeline writeback, which has no backpressure;
  - the long-latency mult/div unit, which uses a valid/ready handshake.
- Queues mult/div results in a small FIFO.
- Keeps a pending-write scoreboard so the decode stage can stall on RAW hazards against outstanding long-latency results.

Parameters:
- DEPTH, 4, mult/div result FIFO entries (power of two, >=2).
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may be denied the write port before stallReq is raised.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wbValid  in  1  pipeline writeback valid
- wbAddr  in  5  pipeline destination register
- wbData  in  32  pipeline result
- mdValid  in  1  mult/div result valid
- mdReady  out  1  FIFO can accept (= !full)
- mdAddr  in  5  mult/div destination register
- mdData  in  32  mult/div result
- issueValid  in  1  long-latency op issued this cycle
- issueAddr  in  5  its destination register
- query1  in  5  decode source register 1
- query2  in  5  decode source register 2
- pending1  out  1  query1 has an outstanding long-latency write
- pending2  out  1  query2 has an outstanding long-latency write
- stallReq  out  1  pipeline must hold wbValid low next cycle
- writeAddr  out  5  register file write address
- writeData  out  32  register file write data
- writeEn  out  1  register file write enable
- fifoCount  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - writeEn=0, writeAddr=0, writeData=0, stallReq=0.
  - FIFO empty: fifoCount=0, mdReady=1.
  - All scoreboard bits cleared; starvation counter cleared.
  - Reset mid-operation discards queued results.
- Write-port registers: writeAddr/writeData/writeEn are flops loaded from the selected source each cycle.
- Selection priority:
  1. wbValid wins.
  2. Otherwise the FIFO head, if non-empty.
  3. Otherwise nothing: writeEn=0 and addr/data hold their previous values.
- Latency:
  - pipeline write appears on the port 1 cycle after wbValid;
  - mult/div write appears at least 2 cycles after the handshake, because every result passes through the FIFO (no bypass).
- $zero: any selected write with address 0 yields writeEn=0. A FIFO entry with address 0 is still popped.
- FIFO push: on mdValid && mdReady.
- FIFO pop: when the head is selected.
- Push and pop may occur in the same cycle: count unchanged; order preserved.
- No push when full. mdValid with mdReady=0 holds the request; the source must keep mdAddr/mdData stable.
- Pointers wrap modulo DEPTH.
- Scoreboard: 32 bits, bit 0 hardwired 0.
  - issueValid sets bit[issueAddr].
  - The bit clears in the cycle the FIFO entry for that register is popped.
  - Simultaneous set and clear of the same register: set wins.
  - pending1/pending2 are combinational reads of the scoreboard.
  - Issuing to an already-pending register is forbidden for the issuer; the bench asserts it.
- Starvation counter:
  - increments each cycle the FIFO is non-empty and wbValid=1;
  - clears when the FIFO pops or becomes empty.
  - When the count reaches STARVE_MAX, stallReq=1 (registered) for exactly one cycle. The counter resets at the same time.
  - The pipeline guarantees wbValid=0 in the stallReq cycle, so the FIFO head drains.
- wbValid=1 during a stallReq cycle is a protocol violation. Pipeline still wins the port; bench flags an error.

Decomposition:
- Shared package mips_pkg:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0;
  - typedef for the {addr,data} writeback record.
- One natural sub-module: wb_result_fifo. Parameterized DEPTH, record width, count output, full/empty.
- Arbiter, scoreboard and starvation counter stay in the top module.

Test Plan:
- Reset, then wbValid=1, wbAddr=5, wbData=32'hDEADBEEF -> next cycle writeEn=1, writeAddr=5, writeData=32'hDEADBEEF.
- issueValid with issueAddr=9; query1=9 -> pending1=1. Pipeline idle, then mdValid with 9/32'h1234 -> writeEn two cycles after the handshake. pending1 drops in the pop cycle.
- Push 4 mult/div results with wbValid held high -> fifoCount=4 and mdReady=0. A 5th mdValid is held until a pop.
- Hold wbValid=1 for 8 cycles with FIFO non-empty (STARVE_MAX=8) -> stallReq=1 for one cycle. With wbValid=0 next cycle, the FIFO head is written.
- wbValid with wbAddr=0, and FIFO entry addr=0 -> writeEn stays 0. FIFO count decrements.
- Assert rst_n=0 mid-queue with 3 entries and 2 pending bits -> immediately fifoCount=0, pending1/pending2=0, writeEn=0, mdReady=1.
